// File: rtl/lsu.sv
// Load/store unit for the multicycle RV32I core: single-beat request/ready data-memory access,
// byte-lane steering, write strobes and load extension. Optional LSU_MISALIGN_CHECK_EN rejects misaligned accesses.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Handshake: mem_req holds address/strobes/data constant until a cycle with mem_ready=1;
  // that cycle completes the transfer and mem_req drops the next cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        ld_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        fault_q;

  logic        req_valid;
  logic        f3_legal;
  logic        misaligned;
  logic        reject;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [3:0]  strb;
  logic [31:0] wdata;

  // Acceptance decision on the raw inputs; load wins when both kinds are flagged.
  always_comb begin
    req_valid  = start && (is_load || is_store);
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`endif
    reject = !f3_legal || misaligned;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = reject ? RESP : REQ;
      REQ:     if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ld_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      fault_q     <= 1'b0;
      load_result <= 32'h0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        ld_q    <= is_load;
        f3_q    <= funct3;
        addr_q  <= addr;
        sdata_q <= store_data;
        fault_q <= reject;
      end
      if (state == REQ && mem_ready && ld_q) begin
        load_result <= load_ext;
      end
    end
  end

  // Lane steering works only from the registered copies; halfword/word ignore the low
  // address bits so an unchecked misaligned access lands on its natural lanes.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (f3_q[1:0])
      2'b00: begin
        load_ext = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
        strb     = 4'b0001 << addr_q[1:0];
        wdata    = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        load_ext = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
        strb     = 4'b0011 << {addr_q[1], 1'b0};
        wdata    = {2{sdata_q[15:0]}};
      end
      default: begin
        load_ext = mem_rdata;
        strb     = 4'b1111;
        wdata    = sdata_q;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == RESP);
    fault     = (state == RESP) && fault_q;
    mem_req   = (state == REQ);
    mem_we    = mem_req && !ld_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wstrb = mem_we ? strb : 4'b0000;
    mem_wdata = mem_we ? wdata : 32'h0;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a cycle-level expectation model driven by access tasks,
// a per-cycle compare process, and a few literal checks on known load results.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_result;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  lsu dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .fault(fault), .load_result(load_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        e_busy, e_done, e_fault, e_req, e_we, e_ld_done;
  logic [31:0] e_addr, e_wdata, e_lr;
  logic [3:0]  e_wstrb;
  logic [31:0] exp_q[$];
  bit          cmp_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit legal(bit ld, logic [2:0] f);
    if (ld) return (f == 3'b000 || f == 3'b001 || f == 3'b010 || f == 3'b100 || f == 3'b101);
    return (f == 3'b000 || f == 3'b001 || f == 3'b010);
  endfunction

  function automatic bit misal(logic [2:0] f, logic [31:0] a);
    bit en;
`ifdef LSU_MISALIGN_CHECK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    if (f == 3'b001 || f == 3'b101) return en && (a % 2 != 0);
    if (f == 3'b010) return en && (a % 4 != 0);
    return 1'b0;
  endfunction

  function automatic logic [3:0] strb_of(logic [2:0] f, logic [31:0] a);
    if (f == 3'b000) return 4'(1 << (a % 4));
    if (f == 3'b001) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_of(logic [2:0] f, logic [31:0] d);
    if (f == 3'b000) return (d & 32'hFF) * 32'h01010101;
    if (f == 3'b001) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ext(logic [2:0] f, logic [31:0] a, logic [31:0] r);
    logic [31:0] v;
    if (f == 3'b000 || f == 3'b100) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (f == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (f == 3'b001 || f == 3'b101) begin
      v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (f == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("fault", 32'(fault), 32'(e_fault));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("load_result", load_result, e_lr);
      if (e_ld_done) begin
        if (exp_q.size() > 0) chk("load_q", load_result, exp_q.pop_front());
        else chk("load_q_empty", 32'd0, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_busy = 0; e_done = 0; e_fault = 0; e_req = 0; e_we = 0;
    e_addr = 0; e_wstrb = 0; e_wdata = 0; e_ld_done = 0;
  endtask

  task automatic set_req(bit ld, logic [2:0] f, logic [31:0] a, logic [31:0] sd);
    e_busy = 1; e_done = 0; e_fault = 0; e_req = 1; e_we = !ld; e_ld_done = 0;
    e_addr  = a - (a % 4);
    e_wstrb = ld ? 4'b0000 : strb_of(f, a);
    e_wdata = ld ? 32'h0 : wdata_of(f, sd);
  endtask

  task automatic access(bit ld, bit st, logic [2:0] f, logic [31:0] a, logic [31:0] sd,
                        logic [31:0] rd, int waits);
    bit rej;
    rej = !legal(ld, f) || misal(f, a);
    start = 1; is_load = ld; is_store = st; funct3 = f; addr = a; store_data = sd;
    mem_rdata = ~rd; mem_ready = 1;  // ready while idle must be ignored
    set_idle();
    step();
    start = 0; addr = ~a; store_data = ~sd; funct3 = ~f; is_load = !ld; is_store = !st;
    mem_ready = 0;
    if (!ld && !st) begin
      set_idle();
      return;
    end
    if (rej) begin
      e_busy = 1; e_done = 1; e_fault = 1; e_req = 0;
      step();
      set_idle();
      return;
    end
    set_req(ld, f, a, sd);
    mem_ready = (waits == 0);
    mem_rdata = (waits == 0) ? rd : ~rd;
    for (int i = 1; i <= waits; i++) begin
      step();
      start = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h0;
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rd : ~rd;
    end
    step();
    start = 1; is_load = 1; is_store = 0; funct3 = 3'b000; mem_ready = 0; mem_rdata = 32'h0;
    set_idle();
    e_busy = 1; e_done = 1;
    if (ld) begin
      e_lr = ext(f, a, rd);
      exp_q.push_back(e_lr);
      e_ld_done = 1;
    end
    step();
    start = 0;
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; start = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_ready = 0; mem_rdata = 0;
    set_idle();
    e_lr = 0;
    step();
    cmp_en = 1;
    step();
    rst = 0;
    step();

    // model pins
    chk("model_sb_strb", 32'(strb_of(3'b000, 32'h201)), 32'h2);
    chk("model_sb_wdata", wdata_of(3'b000, 32'h123456A5), 32'hA5A5A5A5);
    chk("model_sh_strb", 32'(strb_of(3'b001, 32'h202)), 32'hC);

    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);  // LB
    chk("lit_lb", load_result, 32'hFFFFFF80);
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF0000, 0);  // LHU
    chk("lit_lhu", load_result, 32'h0000BEEF);
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'hBEEF0000, 1);  // LH
    chk("lit_lh", load_result, 32'hFFFFBEEF);
    access(0, 1, 3'b000, 32'h201, 32'h123456A5, 32'h0, 0);  // SB
    chk("lit_sb_keeps_lr", load_result, 32'hFFFFBEEF);
    access(0, 1, 3'b010, 32'h300, 32'hDEADBEEF, 32'h0, 3);  // SW, 3 wait cycles
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0);  // LW misaligned
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lit_lw_misal_keeps_lr", load_result, 32'hFFFFBEEF);
`else
    chk("lit_lw_misal", load_result, 32'h11223344);
`endif
    access(1, 0, 3'b011, 32'h100, 32'h0, 32'h55, 0);        // illegal load
    access(0, 1, 3'b011, 32'h100, 32'h77, 32'h0, 0);        // illegal store
    access(1, 0, 3'b110, 32'h104, 32'h0, 32'h55, 0);
    access(0, 1, 3'b100, 32'h104, 32'h77, 32'h0, 0);        // LBU code is not a store
    access(0, 0, 3'b010, 32'h104, 32'h77, 32'h0, 0);        // no kind: ignored
    access(1, 1, 3'b100, 32'h002, 32'h99, 32'h00AB0000, 0); // both set: load wins
    chk("lit_lbu_both", load_result, 32'h000000AB);
    access(0, 1, 3'b001, 32'h203, 32'hCAFE1234, 32'h0, 1);  // SH odd address
    access(1, 0, 3'b101, 32'h001, 32'h0, 32'h00008001, 2);  // LHU odd address
    access(0, 1, 3'b001, 32'h202, 32'hCAFE1234, 32'h0, 0);  // SH upper half

    // reset during the REQ wait
    start = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40; mem_ready = 0;
    set_idle();
    step();
    start = 0;
    set_req(1, 3'b010, 32'h40, 32'h0);
    step();
    rst = 1;
    step();
    rst = 0;
    set_idle();
    e_lr = 0;
    step();
    chk("lit_rst_lr", load_result, 32'h0);
    access(1, 0, 3'b010, 32'h44, 32'h0, 32'h00000007, 2);
    chk("lit_after_rst", load_result, 32'h00000007);

    step();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the multicycle RV32I core. Started by the control FSM during the execute state for load and store instructions. Runs a single-beat request/ready transaction on the data-memory port and handles byte lanes and write strobes. Produces the sign- or zero-extended `load_result` that the register file writes back in the writeback state.

## Interface
- No parameters; data and address width fixed at 32.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: core clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin access; sampled only in IDLE
- `is_load` in 1: access is a load (qualified by `start`)
- `is_store` in 1: access is a store; if both are set, load wins
- `funct3` in 3: RV32I width/sign field
- `addr` in 32: effective byte address (ALU result)
- `store_data` in 32: rs2 value
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle completion pulse
- `fault` out 1: valid with `done`; access was rejected
- `load_result` out 32: extended load data, held until the next completed load
- `mem_req` out 1: bus request
- `mem_we` out 1: store when high
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`
- `mem_wstrb` out 4: byte enables; 0 for loads
- `mem_wdata` out 32: lane-replicated store data
- `mem_ready` in 1: slave accepts/returns data this cycle
- `mem_rdata` in 32: read data, valid when `mem_ready`

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE to REQ: `start` is high, (`is_load` or `is_store`), funct3 is legal, and the access is not rejected.
- IDLE to RESP with the fault flag set: `start` is high and the access is rejected. No bus cycle is issued.
- REQ to RESP: `mem_ready` is high while `mem_req` is high.
- RESP to IDLE: always, after one cycle.
- `start` without `is_load` or `is_store` is ignored.
- `start` outside IDLE is ignored.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB, 001 SH, 010 SW.
- Any other funct3 is always rejected (fault).
- Byte select uses `addr[1:0]`; halfword select uses `addr[1]`.
- LB/LH sign-extend from bit 7/15 of the selected lane. LBU/LHU zero-extend.
- SB: `mem_wstrb = 4'b0001 << addr[1:0]`; `mem_wdata` = `store_data[7:0]` replicated ×4.
- SH: `mem_wstrb = 4'b0011 << {addr[1],1'b0}`; `mem_wdata` = `store_data[15:0]` replicated ×2.
- SW: `mem_wstrb = 4'b1111`; `mem_wdata` = `store_data`.
- `addr`, `funct3`, `store_data` and the load/store kind are registered at `start`. The bus outputs and extension use only the registered copies, so inputs may change after the `start` cycle.
- `load_result` updates only on a successful load, in the REQ to RESP transition. Stores and faults leave it unchanged.

## Timing
- Reset values: `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `mem_wstrb` = 0; `mem_addr`, `mem_wdata`, `load_result` = 0; state = IDLE.
- Cycle N: `start` accepted. Cycle N+1: `mem_req`=1 with the address, strobes and data stable.
- `mem_req` and all bus outputs are held constant until the cycle in which `mem_ready`=1. `mem_req` drops the following cycle.
- With zero-wait memory (`mem_ready`=1 at N+1): `done`=1 and `load_result` valid at N+2. Each wait cycle adds one cycle.
- Fault path: `done`=1 and `fault`=1 at N+1; `mem_req` never asserts.
- `done` is high only in RESP; `busy` is low in the same cycle `done` would be followed by IDLE, i.e. in the cycle after RESP.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset during REQ: `mem_req` is 0 on the next cycle, no `done` is issued, and `load_result` is cleared.
- `start` in the RESP cycle is ignored; the next access can be accepted no earlier than the cycle after RESP.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - LH/LHU/SH with `addr[0]`=1 fault.
  - LW/SW with `addr[1:0]`≠0 fault.
- Not defined:
  - No misalignment fault.
  - Halfword ignores `addr[0]`; word ignores `addr[1:0]`.
  - Access proceeds on the naturally aligned lane(s).
  - Illegal-funct3 fault is unaffected.

## Test plan
- LB, addr 0x103, `mem_rdata` 0x80FF1234, zero-wait: `mem_addr` 0x100, `mem_wstrb` 0, `done` at N+2, `load_result` 0xFFFFFF80.
- LHU, addr 0x102, `mem_rdata` 0xBEEF0000: `load_result` 0x0000BEEF; then LH of the same data gives 0xFFFFBEEF.
- SB, addr 0x201, `store_data` 0x123456A5: `mem_we`=1, `mem_addr` 0x200, `mem_wstrb` 0010, `mem_wdata` 0xA5A5A5A5, `load_result` unchanged.
- SW with `mem_ready` delayed 3 cycles: bus outputs stable for 4 cycles, `done` at N+5. A second `start` while busy is ignored.
- LW at 0x102: with the macro, `fault`=1 with `done` at N+1 and no `mem_req`. Without it, `mem_addr` 0x100 and normal completion. funct3=011 faults in both builds.
- `rst` asserted during the REQ wait: `mem_req` low next cycle, no `done`, `load_result` 0, and a new `start` is accepted afterwards.
